// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf_pkg
// Purpose : Shared constants for the GF(2^WIDTH) vector-add controller.
// Revision: 1.0
// ============================================================================
package gf_pkg;

    localparam int GF_WIDTH = 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    function automatic int gf_lat(input int reg_in, input int reg_out);
        return reg_in + reg_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf_add.sv
`default_nettype none
// ============================================================================
// Module  : gf_add
// Purpose : GF(2^WIDTH) adder (bitwise xor) with optional in/out registers.
// Revision: 1.0
// ============================================================================
module gf_add
    import gf_pkg::*;
#(
    parameter int WIDTH   = GF_WIDTH,
    parameter int REG_IN  = 0,
    parameter int REG_OUT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_data
);

    logic             w_in_vld;
    logic [WIDTH-1:0] w_in_a;
    logic [WIDTH-1:0] w_in_b;
    logic [WIDTH-1:0] w_sum;

    generate
        if (REG_IN != 0) begin : g_reg_in
            logic             r_vld;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                end else begin
                    r_vld <= i_start;
                    r_a   <= i_a;
                    r_b   <= i_b;
                end
            end
            assign w_in_vld = r_vld;
            assign w_in_a   = r_a;
            assign w_in_b   = r_b;
        end else begin : g_no_reg_in
            assign w_in_vld = i_start;
            assign w_in_a   = i_a;
            assign w_in_b   = i_b;
        end
    endgenerate

    // Result is forced to zero when not valid so idle outputs stay quiet.
    assign w_sum = w_in_vld ? (w_in_a ^ w_in_b) : '0;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic             r_vld;
            logic [WIDTH-1:0] r_data;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_vld  <= w_in_vld;
                    r_data <= w_sum;
                end
            end
            assign o_done = r_vld;
            assign o_data = r_data;
        end else begin : g_no_reg_out
            assign o_done = w_in_vld;
            assign o_data = w_sum;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gf_vec_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gf_vec_add_ctrl
// Purpose : Streams two operand vectors through gf_add into a result memory.
// Revision: 1.0
// ============================================================================
module gf_vec_add_ctrl
    import gf_pkg::*;
#(
    parameter int WIDTH   = GF_WIDTH,
    parameter int N       = 256,
    parameter int ADDR_W  = 8,
    parameter int REG_IN  = 0,
    parameter int REG_OUT = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]  i_data_a,
    input  logic [WIDTH-1:0]  i_data_b,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int              c_LAT = gf_lat(REG_IN, REG_OUT);
    localparam logic [ADDR_W:0] c_N   = N[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};

    generate
        if (((2 ** ADDR_W) < N) || (c_LAT > 2)) begin : g_param_err
            $error("gf_vec_add_ctrl: ADDR_W too small for N or bad REG_IN/REG_OUT");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_wr_cnt;
    logic              r_rd_en_d;
    logic              w_wr_en;
    logic [WIDTH-1:0]  w_sum;
    logic [ADDR_W:0]   w_len_clamped;
    logic [ADDR_W:0]   w_wr_cnt_next;

    assign w_len_clamped = (i_len > c_N) ? c_N : i_len;
    assign w_wr_cnt_next = r_wr_cnt + {{ADDR_W{1'b0}}, w_wr_en};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_ST_IDLE;
            r_len     <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rd_en_d <= 1'b0;
        end else begin
            r_rd_en_d <= (r_state == c_ST_READ);
            r_wr_cnt  <= w_wr_cnt_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_len    <= w_len_clamped;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_state  <= (w_len_clamped == '0) ? c_ST_DONE : c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    r_rd_cnt <= r_rd_cnt + c_ONE;
                    if (r_rd_cnt == (r_len - c_ONE)) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    // Look at the post-write count so DONE follows the last write directly.
                    if (w_wr_cnt_next == r_len) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    gf_add #(
        .WIDTH   (WIDTH),
        .REG_IN  (REG_IN),
        .REG_OUT (REG_OUT)
    ) u_gf_add (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (r_rd_en_d),
        .i_a     (i_data_a),
        .i_b     (i_data_b),
        .o_done  (w_wr_en),
        .o_data  (w_sum)
    );

    assign o_rd_en   = (r_state == c_ST_READ);
    assign o_rd_addr = o_rd_en ? r_rd_cnt[ADDR_W-1:0] : '0;
    assign o_wr_en   = w_wr_en;
    assign o_wr_addr = w_wr_en ? r_wr_cnt[ADDR_W-1:0] : '0;
    assign o_wr_data = w_sum;
    assign o_busy    = (r_state == c_ST_READ) || (r_state == c_ST_DRAIN);
    assign o_done    = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gf_vec_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf_vec_add_ctrl
// Purpose : Directed self-checking bench; LAT=0 and LAT=2 instances side by side.
// Revision: 1.0
// ============================================================================
module tb_gf_vec_add_ctrl;

    localparam int WIDTH  = 8;
    localparam int N      = 256;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len   = '0;

    logic              rd_en0, wr_en0, busy0, done0;
    logic [ADDR_W-1:0] rd_addr0, wr_addr0;
    logic [WIDTH-1:0]  da0, db0, wr_data0;
    logic              rd_en1, wr_en1, busy1, done1;
    logic [ADDR_W-1:0] rd_addr1, wr_addr1;
    logic [WIDTH-1:0]  da1, db1, wr_data1;

    gf_vec_add_ctrl #(.WIDTH(WIDTH), .N(N), .ADDR_W(ADDR_W), .REG_IN(0), .REG_OUT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
        .o_rd_en(rd_en0), .o_rd_addr(rd_addr0), .i_data_a(da0), .i_data_b(db0),
        .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
        .o_busy(busy0), .o_done(done0)
    );

    gf_vec_add_ctrl #(.WIDTH(WIDTH), .N(N), .ADDR_W(ADDR_W), .REG_IN(1), .REG_OUT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
        .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_data_a(da1), .i_data_b(db1),
        .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
        .o_busy(busy1), .o_done(done1)
    );

    logic [WIDTH-1:0] mem_a [N];
    logic [WIDTH-1:0] mem_b [N];

    always @(posedge clk) begin
        if (rd_en0) begin
            da0 <= mem_a[rd_addr0];
            db0 <= mem_b[rd_addr0];
        end
        if (rd_en1) begin
            da1 <= mem_a[rd_addr1];
            db1 <= mem_b[rd_addr1];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle; index [d] selects dut0 / dut1.
    int              wr_n [2] = '{0, 0};
    int              rd_n [2] = '{0, 0};
    int              done_n [2] = '{0, 0};
    int              done_c [2] = '{0, 0};
    logic [7:0]      wr_a [2][1024];
    logic [7:0]      wr_d [2][1024];
    int              wr_c [2][1024];
    logic [1:0]      busy_h [2048];

    always @(negedge clk) begin
        busy_h[cyc & 2047] <= {busy1, busy0};
        if (wr_en0) begin
            wr_a[0][wr_n[0]] <= wr_addr0;
            wr_d[0][wr_n[0]] <= wr_data0;
            wr_c[0][wr_n[0]] <= cyc;
            wr_n[0]          <= wr_n[0] + 1;
        end
        if (wr_en1) begin
            wr_a[1][wr_n[1]] <= wr_addr1;
            wr_d[1][wr_n[1]] <= wr_data1;
            wr_c[1][wr_n[1]] <= cyc;
            wr_n[1]          <= wr_n[1] + 1;
        end
        if (rd_en0) rd_n[0] <= rd_n[0] + 1;
        if (rd_en1) rd_n[1] <= rd_n[1] + 1;
        if (done0) begin
            done_n[0] <= done_n[0] + 1;
            done_c[0] <= cyc;
        end
        if (done1) begin
            done_n[1] <= done_n[1] + 1;
            done_c[1] <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    int t0, bw0, bw1, br0, br1, bd0, bd1;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // t0 is the cycle in which start is held high (its sampling edge ends it).
    task automatic launch(input logic [ADDR_W:0] l);
        step();
        t0  = cyc;
        bw0 = wr_n[0]; bw1 = wr_n[1];
        br0 = rd_n[0]; br1 = rd_n[1];
        bd0 = done_n[0]; bd1 = done_n[1];
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((done_n[0] == bd0 || done_n[1] == bd1) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (done_n[0] == bd0 || done_n[1] == bd1) begin
            errors++;
            $display("FAIL wait_done: no o_done within %0d cycles (dut0 %0d dut1 %0d new), required 1 each",
                     limit, done_n[0] - bd0, done_n[1] - bd1);
        end
        repeat (4) step();
    endtask

    task automatic load_basic();
        logic [7:0] a [4] = '{8'he9, 8'h01, 8'hff, 8'h80};
        logic [7:0] b [4] = '{8'h05, 8'h01, 8'h0f, 8'h80};
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = a[k];
            mem_b[k] = b[k];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, busy0, done0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: outputs %h, required 0",
                     {rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, busy0, done0});
        end
        checks++;
        if ({rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: outputs %h, required 0",
                     {rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, busy1, done1});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic check_vec4(input int d, input int lat, input int bw);
        logic [7:0] exp_d [4] = '{8'hec, 8'h00, 8'hf0, 8'h00};
        checks++;
        if (wr_n[d] - bw !== 4) begin
            errors++;
            $display("FAIL wr_count dut%0d: got %0d, required 4", d, wr_n[d] - bw);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_a[d][bw+k] !== 8'(k) || wr_d[d][bw+k] !== exp_d[k] || wr_c[d][bw+k] !== t0 + 2 + k + lat) begin
                errors++;
                $display("FAIL write%0d dut%0d: addr %h data %h cycle %0d, required addr %h data %h cycle %0d",
                         k, d, wr_a[d][bw+k], wr_d[d][bw+k], wr_c[d][bw+k] - t0, 8'(k), exp_d[k], 2 + k + lat);
            end
        end
    endtask

    task automatic test_basic();
        load_basic();
        launch(9'd4);
        wait_done(40);
        check_vec4(0, 0, bw0);
        checks++;
        if (done_n[0] - bd0 !== 1 || done_c[0] !== t0 + 6) begin
            errors++;
            $display("FAIL basic_done: count %0d at T+%0d, required 1 at T+6", done_n[0] - bd0, done_c[0] - t0);
        end
        checks++;
        if (rd_n[0] - br0 !== 4) begin
            errors++;
            $display("FAIL basic_reads: got %0d, required 4", rd_n[0] - br0);
        end
        for (int k = 0; k <= 6; k++) begin
            checks++;
            if (busy_h[(t0 + k) & 2047][0] !== ((k >= 1 && k <= 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL basic_busy T+%0d: got %b, required %b", k, busy_h[(t0 + k) & 2047][0],
                         (k >= 1 && k <= 5) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_latency();
        load_basic();
        launch(9'd4);
        wait_done(40);
        check_vec4(1, 2, bw1);
        checks++;
        if (done_n[1] - bd1 !== 1 || done_c[1] !== t0 + 8) begin
            errors++;
            $display("FAIL lat_done: count %0d at T+%0d, required 1 at T+8", done_n[1] - bd1, done_c[1] - t0);
        end
    endtask

    task automatic test_zero_len();
        launch(9'd0);
        wait_done(20);
        checks++;
        if (done_n[0] - bd0 !== 1 || done_c[0] !== t0 + 1 || done_n[1] - bd1 !== 1 || done_c[1] !== t0 + 1) begin
            errors++;
            $display("FAIL zero_done: dut0 %0d at T+%0d dut1 %0d at T+%0d, required 1 at T+1 each",
                     done_n[0] - bd0, done_c[0] - t0, done_n[1] - bd1, done_c[1] - t0);
        end
        checks++;
        if (rd_n[0] != br0 || rd_n[1] != br1 || wr_n[0] != bw0 || wr_n[1] != bw1) begin
            errors++;
            $display("FAIL zero_traffic: reads %0d/%0d writes %0d/%0d, required 0",
                     rd_n[0] - br0, rd_n[1] - br1, wr_n[0] - bw0, wr_n[1] - bw1);
        end
    endtask

    task automatic run_full(input logic [ADDR_W:0] l, input string name);
        for (int k = 0; k < N; k++) begin
            mem_a[k] = 8'(k);
            mem_b[k] = 8'hff;
        end
        launch(l);
        wait_done(400);
        checks++;
        if (wr_n[0] - bw0 !== N || done_n[0] - bd0 !== 1 || done_c[0] !== t0 + N + 2) begin
            errors++;
            $display("FAIL %s_count: writes %0d done %0d at T+%0d, required %0d writes 1 done at T+%0d",
                     name, wr_n[0] - bw0, done_n[0] - bd0, done_c[0] - t0, N, N + 2);
        end
        checks++;
        if (wr_n[1] - bw1 !== N || done_n[1] - bd1 !== 1 || done_c[1] !== t0 + N + 4) begin
            errors++;
            $display("FAIL %s_lat: writes %0d done %0d at T+%0d, required %0d writes 1 done at T+%0d",
                     name, wr_n[1] - bw1, done_n[1] - bd1, done_c[1] - t0, N, N + 4);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (wr_a[0][bw0+k] !== 8'(k) || wr_d[0][bw0+k] !== ~8'(k)) begin
                errors++;
                $display("FAIL %s_write%0d: addr %h data %h, required addr %h data %h",
                         name, k, wr_a[0][bw0+k], wr_d[0][bw0+k], 8'(k), ~8'(k));
            end
        end
    endtask

    task automatic test_full_len();
        run_full(9'd256, "full");
    endtask

    task automatic test_clamp();
        run_full(9'd300, "clamp");
    endtask

    task automatic test_start_busy();
        load_basic();
        launch(9'd4);
        start = 1'b1;
        len   = 9'd2;
        step();
        start = 1'b0;
        wait_done(40);
        check_vec4(0, 0, bw0);
        checks++;
        if (done_n[0] - bd0 !== 1 || done_n[1] - bd1 !== 1 || wr_n[1] - bw1 !== 4) begin
            errors++;
            $display("FAIL busy_start: done %0d/%0d lat writes %0d, required 1/1 and 4",
                     done_n[0] - bd0, done_n[1] - bd1, wr_n[1] - bw1);
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        launch(9'd4);
        while (cyc < t0 + 3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({rd_en0, wr_en0, wr_data0, busy0, done0, rd_en1, wr_en1, wr_data1, busy1, done1,
                 rd_addr0, wr_addr0, rd_addr1, wr_addr1} !== '0) begin
                errors++;
                $display("FAIL rst_mid_quiet T+%0d: dut0 rd %b wr %b busy %b done %b dut1 rd %b wr %b busy %b done %b, required all 0",
                         cyc - t0, rd_en0, wr_en0, busy0, done0, rd_en1, wr_en1, busy1, done1);
            end
            step();
        end
        checks++;
        if (done_n[0] != bd0 || done_n[1] != bd1 || wr_n[0] - bw0 !== 2 || wr_n[1] != bw1) begin
            errors++;
            $display("FAIL rst_mid_events: done %0d/%0d writes %0d/%0d, required done 0/0 writes 2/0",
                     done_n[0] - bd0, done_n[1] - bd1, wr_n[0] - bw0, wr_n[1] - bw1);
        end
        launch(9'd1);
        wait_done(20);
        checks++;
        if (wr_n[0] - bw0 !== 1 || wr_a[0][bw0] !== 8'h00 || wr_d[0][bw0] !== 8'hec || wr_c[0][bw0] !== t0 + 2) begin
            errors++;
            $display("FAIL rst_restart_write: n %0d addr %h data %h at T+%0d, required 1 write 00/ec at T+2",
                     wr_n[0] - bw0, wr_a[0][bw0], wr_d[0][bw0], wr_c[0][bw0] - t0);
        end
        checks++;
        if (done_c[0] !== t0 + 3 || done_c[1] !== t0 + 5 || wr_d[1][bw1] !== 8'hec) begin
            errors++;
            $display("FAIL rst_restart_done: dut0 T+%0d dut1 T+%0d lat data %h, required T+3 T+5 ec",
                     done_c[0] - t0, done_c[1] - t0, wr_d[1][bw1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_zero_len();
        test_full_len();
        test_clamp();
        test_start_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
